boron_round_ctrl: RTL and testbench

Iterative Boron encryption controller. Accepts one 64-bit plaintext and key per transaction, sequences NUM_ROUNDS rounds over a single-round datapath (add round key, S-box layer, block shuffle, 16-bit word XOR mixing), runs the key schedule in lockstep, and returns the key-whitened ciphertext over a valid/ready handshake. It is the top-level engine of the cipher and owns all round-level state.

---
 rtl/boron_round_ctrl.sv | 164 ++++++++++++++++
 tb/tb_boron_round_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boron_round_ctrl.sv
// Iterative Boron block cipher engine: one round per cycle, key schedule in lockstep.
// Define BORON_KEY128_EN for the 128-bit key path; the default build uses 80-bit keys.
module boron_round_ctrl #(
   parameter int unsigned NUM_ROUNDS = 25,
`ifdef BORON_KEY128_EN
   localparam int unsigned KEY_W = 128
`else
   localparam int unsigned KEY_W = 80
`endif
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [63:0]       data_i,
   input  logic [KEY_W-1:0]  key_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [63:0]       data_o,
   output logic              busy_o,
   output logic [4:0]        round_o
);

   localparam logic [4:0] LAST_RC = 5'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_e;

   state_e             fsm_q, fsm_d;
   logic [63:0]        state_q, state_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [4:0]         rc_q, rc_d;
   logic [63:0]        dout_q, dout_d;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hE;
         4'h1: y = 4'h4;
         4'h2: y = 4'hB;
         4'h3: y = 4'h1;
         4'h4: y = 4'h7;
         4'h5: y = 4'h9;
         4'h6: y = 4'hC;
         4'h7: y = 4'hA;
         4'h8: y = 4'hD;
         4'h9: y = 4'h2;
         4'hA: y = 4'h0;
         4'hB: y = 4'hF;
         4'hC: y = 4'h8;
         4'hD: y = 4'h5;
         4'hE: y = 4'h3;
         default: y = 4'h6;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] sbox_layer(input logic [63:0] x);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[4*i +: 4] = sbox4(x[4*i +: 4]);
      end
      return r;
   endfunction

   function automatic logic [15:0] rotl16(input logic [15:0] w, input int unsigned n);
      logic [31:0] t;
      t = {w, w} << n;
      return t[31:16];
   endfunction

   function automatic logic [63:0] shuf(input logic [63:0] x);
      return {rotl16(x[63:48], 9), rotl16(x[47:32], 7),
              rotl16(x[31:16], 4), rotl16(x[15:0], 1)};
   endfunction

   // Word-level XOR mixing; output words packed in input word order.
   function automatic logic [63:0] mix(input logic [63:0] x);
      logic [15:0] w0, w1, w2, w3;
      w0 = x[15:0];
      w1 = x[31:16];
      w2 = x[47:32];
      w3 = x[63:48];
      return {w3 ^ w2 ^ w0, w2 ^ w0, w3 ^ w1, w3 ^ w1 ^ w0};
   endfunction

   function automatic logic [KEY_W-1:0] upd(input logic [KEY_W-1:0] k,
                                            input logic [4:0]       rc);
      logic [KEY_W-1:0] r;
      r = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
      r[3:0] = sbox4(r[3:0]);
`ifdef BORON_KEY128_EN
      r[7:4] = sbox4(r[7:4]);
`endif
      r[63:59] = r[63:59] ^ rc;
      return r;
   endfunction

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      rc_d    = rc_q;
      dout_d  = dout_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid_i) begin
               state_d = data_i;
               key_d   = key_i;
               rc_d    = 5'd1;
               fsm_d   = S_ROUND;
            end
         end
         S_ROUND: begin
            state_d = mix(shuf(sbox_layer(state_q ^ key_q[63:0])));
            key_d   = upd(key_q, rc_q);
            // The last round keeps rc so round_o holds NUM_ROUNDS until DONE is left.
            if (rc_q == LAST_RC) begin
               fsm_d = S_FINAL;
            end else begin
               rc_d = rc_q + 5'd1;
            end
         end
         S_FINAL: begin
            dout_d = state_q ^ key_q[63:0];
            fsm_d  = S_DONE;
         end
         default: begin
            if (out_ready_i) begin
               rc_d  = 5'd0;
               fsm_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q   <= S_IDLE;
         state_q <= '0;
         key_q   <= '0;
         rc_q    <= '0;
         dout_q  <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         key_q   <= key_d;
         rc_q    <= rc_d;
         dout_q  <= dout_d;
      end
   end

   assign in_ready_o  = (fsm_q == S_IDLE);
   assign out_valid_o = (fsm_q == S_DONE);
   assign busy_o      = (fsm_q == S_ROUND) || (fsm_q == S_FINAL);
   assign round_o     = rc_q;
   assign data_o      = dout_q;

endmodule

// File: tb/tb_boron_round_ctrl.sv
// Scoreboard bench for boron_round_ctrl; a second instance with one round checks hand-derived vectors.
module tb_boron_round_ctrl;

`ifdef BORON_KEY128_EN
   localparam int KW = 128;
`else
   localparam int KW = 80;
`endif
   localparam int NR = 25;

   typedef struct {
      logic [63:0] d;
      int          acc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid, in_ready, out_valid, out_ready, busy;
   logic [63:0]    data, data_o;
   logic [KW-1:0]  key;
   logic [4:0]     round;

   logic           u_in_valid, u_in_ready, u_out_valid, u_busy;
   logic [63:0]    u_data, u_data_o;
   logic [KW-1:0]  u_key;
   logic [4:0]     u_round;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];

   boron_round_ctrl #(.NUM_ROUNDS(NR)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .data_i(data), .key_i(key), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .data_o(data_o), .busy_o(busy), .round_o(round)
   );

   boron_round_ctrl #(.NUM_ROUNDS(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(u_in_valid), .in_ready_o(u_in_ready),
      .data_i(u_data), .key_i(u_key), .out_valid_o(u_out_valid), .out_ready_i(1'b1),
      .data_o(u_data_o), .busy_o(u_busy), .round_o(u_round)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Independent reference: nibble table lookup, shift-or rotations.
   function automatic logic [63:0] model(input logic [63:0] pt, input logic [KW-1:0] k0,
                                         input int rounds);
      logic [63:0]   sbt;
      logic [63:0]   s;
      logic [KW-1:0] k;
      logic [15:0]   w0, w1, w2, w3;
      sbt = 64'h6358_F02D_AC97_1B4E;
      s = pt;
      k = k0;
      for (int r = 1; r <= rounds; r++) begin
         s = s ^ k[63:0];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = sbt[4*s[4*n +: 4] +: 4];
         w0 = (s[15:0]  << 1) | (s[15:0]  >> 15);
         w1 = (s[31:16] << 4) | (s[31:16] >> 12);
         w2 = (s[47:32] << 7) | (s[47:32] >> 9);
         w3 = (s[63:48] << 9) | (s[63:48] >> 7);
         s = {w3 ^ w2 ^ w0, w2 ^ w0, w3 ^ w1, w3 ^ w1 ^ w0};
         k = (k << 13) | (k >> (KW - 13));
         k[3:0] = sbt[4*k[3:0] +: 4];
         if (KW == 128) k[7:4] = sbt[4*k[7:4] +: 4];
         k[63:59] = k[63:59] ^ 5'(r);
      end
      return s ^ k[63:0];
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: latency on the rising edge of out_valid, data on each accepted transfer.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n === 1'b1) begin
            if (out_valid && !prev) begin
               if (q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
               else check("latency", 64'(cyc - q[0].acc), 64'(NR + 1));
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) check("unexpected_transfer", 64'd1, 64'd0);
               else begin
                  e = q.pop_front();
                  check("ciphertext", data_o, e.d);
               end
            end
            prev = out_valid;
         end else begin
            prev = 1'b0;
         end
      end
   end

   task automatic issue(input logic [63:0] d, input logic [KW-1:0] k, input bit push,
                        output int acc);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check("issue_timeout", 64'd0, 64'd1);
      data = d;
      key = k;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      if (push) q.push_back('{model(d, k, NR), cyc});
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   task automatic wait_round(input logic [4:0] rc);
      int w;
      w = 0;
      @(negedge clk);
      while (round != rc && w < 60) begin
         @(negedge clk);
         w++;
      end
   endtask

   task automatic hand_vec(input logic [63:0] d, input logic [KW-1:0] k, input logic [63:0] exp);
      int a;
      int w;
      w = 0;
      @(negedge clk);
      u_data = d;
      u_key = k;
      u_in_valid = 1'b1;
      @(posedge clk);
      #1;
      a = cyc;
      u_in_valid = 1'b0;
      do begin
         @(negedge clk);
         #1;
         w++;
      end while (!u_out_valid && w < 10);
      check("hand_latency", 64'(cyc - a), 64'd2);
      check("hand_data", u_data_o, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, prev_acc;
      logic [63:0] d, exp_bp;
      logic [KW-1:0] k, ones;
      int w;
      ones = '1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      data = '0;
      key = '0;
      u_in_valid = 1'b0;
      u_data = '0;
      u_key = '0;
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_data_o", data_o, 64'd0);
      check("rst_round", 64'(round), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // One-round hand vectors
`ifdef BORON_KEY128_EN
      hand_vec(64'h0, '0, 64'h7F77_AAAA_3333_EE00);
      hand_vec(64'hFFFF_FFFF_FFFF_FFFF, ones, 64'h8088_5555_CCCC_1188);
`else
      hand_vec(64'h0, '0, 64'h7F77_AAAA_3333_EEE0);
      hand_vec(64'hFFFF_FFFF_FFFF_FFFF, ones, 64'h8088_5555_CCCC_1118);
`endif

      // Latency with consumer ready
      out_ready = 1'b1;
      issue(64'h0, '0, 1'b1, acc);
      in_valid = 1'b0;
      drain();
      issue(64'hFFFF_FFFF_FFFF_FFFF, ones, 1'b1, acc);
      in_valid = 1'b0;
      drain();

      // Backpressure
      out_ready = 1'b0;
      d = 64'h0123_4567_89AB_CDEF;
      k = KW'(80'h1357_9BDF_0246_8ACE_1122);
      exp_bp = model(d, k, NR);
      issue(d, k, 1'b1, acc);
      in_valid = 1'b0;
      w = 0;
      do begin
         @(negedge clk);
         #1;
         w++;
      end while (!out_valid && w < 60);
      for (int i = 0; i < 40; i++) begin
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_data_hold", data_o, exp_bp);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp_after_valid", 64'(out_valid), 64'd0);
      check("bp_after_ready", 64'(in_ready), 64'd1);
      drain();

      // Busy ignore
      issue(64'hDEAD_BEEF_CAFE_F00D, KW'(80'hA5A5_5A5A_0F0F_F0F0_3C3C), 1'b1, acc);
      in_valid = 1'b0;
      wait_round(5'd5);
      data = 64'h1111_2222_3333_4444;
      key = '0;
      in_valid = 1'b1;
      #1;
      check("busy_round5", 64'(round), 64'd5);
      @(negedge clk);
      #1;
      check("busy_round6", 64'(round), 64'd6);
      @(negedge clk);
      #1;
      check("busy_round7", 64'(round), 64'd7);
      in_valid = 1'b0;
      drain();

      // Reset in mid-round
      issue(64'h5555_AAAA_5555_AAAA, KW'(80'h0F1E_2D3C_4B5A_6978_8796), 1'b0, acc);
      in_valid = 1'b0;
      wait_round(5'd10);
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_data_o", data_o, 64'd0);
      check("arst_round", 64'(round), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_out_valid", 64'(out_valid), 64'd0);

      // Back-to-back with in_valid and out_ready held high
      out_ready = 1'b1;
      prev_acc = 0;
      for (int i = 0; i < 100; i++) begin
         d = {$urandom(), $urandom()};
         k = KW'({$urandom(), $urandom(), $urandom(), $urandom()});
         issue(d, k, 1'b1, acc);
         if (i > 0) check("issue_spacing", 64'(acc - prev_acc), 64'(NR + 3));
         prev_acc = acc;
      end
      in_valid = 1'b0;
      drain();

`ifdef BORON_KEY128_EN
      issue(64'h0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, acc);
      in_valid = 1'b0;
      drain();
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
